// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single frame-SRAM port between N_REQ engines
// (0=bla, 1=fill, 2=alpha, 3=display). One whole-line access per grant,
// all SRAM strobes and client outputs driven from registers.
// Build option: define SRAM_ARB_FIXED_PRIO_EN for lowest-index-wins
// arbitration (display-priority builds); default is round-robin.
module sram_arbiter #(
    parameter int N_REQ         = 4,
    parameter int ADDR_W        = 24,
    parameter int DATA_W        = 1536,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        done,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic                    read_enable,
    output logic                    write_enable,
    output logic [ADDR_W-1:0]       address,
    output logic [DATA_W-1:0]       write_data,
    input  logic [DATA_W-1:0]       read_data
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    // latched grant: who owns the port, direction, strobe cycles left
    typedef struct packed {
        logic [IDX_W-1:0] id;
        logic             wr;
        logic [CNT_W-1:0] cnt;
    } grant_t;

    state_t                         state_q, state_d;
    grant_t                         acc_q;
    logic [IDX_W-1:0]               rr_ptr;
    logic [IDX_W-1:0]               win_nx;
    logic                           win_ok;
    logic                           re_d, we_d, busy_d;
    logic [N_REQ-1:0]               done_d;
    logic [N_REQ-1:0][ADDR_W-1:0]   addr_a;
    logic [N_REQ-1:0][DATA_W-1:0]   wdata_a;

    assign addr_a  = req_addr;
    assign wdata_a = req_wdata;

    // winner select; loops run from lowest to highest priority so the
    // last hit is the winner
    always_comb begin
        win_ok = 1'b0;
        win_nx = '0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[IDX_W'(k)]) begin
                win_ok = 1'b1;
                win_nx = IDX_W'(k);
            end
        end
`else
        for (int k = N_REQ; k >= 1; k--) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (req_valid[IDX_W'(j)]) begin
                win_ok = 1'b1;
                win_nx = IDX_W'(j);
            end
        end
`endif
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_ok) state_d = ACCESS;
            ACCESS:  if (acc_q.cnt == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // next values of the registered outputs; on entry to ACCESS the
    // direction comes straight from the new winner
    always_comb begin
        re_d   = 1'b0;
        we_d   = 1'b0;
        done_d = '0;
        busy_d = (state_d != IDLE);
        if (state_d == ACCESS) begin
            if (state_q == IDLE) begin
                re_d = ~req_write[win_nx];
                we_d =  req_write[win_nx];
            end else begin
                re_d = ~acc_q.wr;
                we_d =  acc_q.wr;
            end
        end
        if (state_d == DONE) done_d[acc_q.id] = 1'b1;
    end

    // output registers, grant latch, strobe counter and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            done         <= '0;
            busy         <= 1'b0;
            rdata        <= '0;
            address      <= '0;
            write_data   <= '0;
            acc_q        <= '0;
            rr_ptr       <= IDX_W'(N_REQ - 1);
        end else begin
            read_enable  <= re_d;
            write_enable <= we_d;
            done         <= done_d;
            busy         <= busy_d;
            case (state_q)
                IDLE: if (win_ok) begin
                    acc_q.id   <= win_nx;
                    acc_q.wr   <= req_write[win_nx];
                    acc_q.cnt  <= CNT_W'(ACCESS_CYCLES - 1);
                    address    <= addr_a[win_nx];
                    write_data <= wdata_a[win_nx];
                end
                ACCESS: begin
                    if (acc_q.cnt == '0) begin
                        if (!acc_q.wr) rdata <= read_data;
                    end else begin
                        acc_q.cnt <= acc_q.cnt - 1'b1;
                    end
                end
                DONE: begin
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    rr_ptr <= acc_q.id;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of sram_arbiter with a small SRAM model.
// A second instance with ACCESS_CYCLES=3 shares the request inputs.
module tb_sram_arbiter;
    localparam int N_REQ  = 4;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 1536;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid, req_write;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]        done, done3;
    logic [DATA_W-1:0]       rdata, rdata3, write_data, wd3, read_data, rd3;
    logic                    busy, busy3, read_enable, write_enable, re3, we3;
    logic [ADDR_W-1:0]       address, addr3;

    logic [DATA_W-1:0]       mem [16];
    logic [15:0]             wr_seen = '0;
    logic                    both_hi = 1'b0;
    int                      checks = 0;
    int                      errors = 0;

    localparam logic [DATA_W-1:0] PAT = {64{24'hFFEEDD}};
    localparam logic [DATA_W-1:0] W5  = {48{32'h5A5A0005}};

    function automatic logic [DATA_W-1:0] mem_init(input int i);
        return {48{32'hC0DE0000 + 32'(i)}};
    endfunction

    sram_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
        .busy(busy), .read_enable(read_enable), .write_enable(write_enable),
        .address(address), .write_data(write_data), .read_data(read_data));

    sram_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .done(done3), .rdata(rdata3),
        .busy(busy3), .read_enable(re3), .write_enable(we3),
        .address(addr3), .write_data(wd3), .read_data(rd3));

    always #5 clk = ~clk;

    // SRAM model: combinational read, write on rising edge
    assign read_data = wr_seen[address[3:0]] ? mem[address[3:0]] : mem_init(int'(address[3:0]));
    always @(posedge clk) begin
        if (write_enable) begin
            mem[address[3:0]]     <= write_data;
            wr_seen[address[3:0]] <= 1'b1;
        end
    end

    // sticky flag: read and write strobes must never overlap
    always @(negedge clk) begin
        if ((read_enable && write_enable) || (re3 && we3)) both_hi <= 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid[i] = v;
        req_write[i] = w;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_write = '0;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        rd3 = {64{24'h123456}};
        cyc(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_re", read_enable, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_addr", address, 0);
        chk("rst_rdata", rdata == '0, 1);
        chk("rst_wdata", write_data == '0, 1);
        rst = 1'b0;

        // write then read back through another requester
        set_req(0, 1, 1, 24'h10, PAT);
        cyc(1);
        chk("t1_we", write_enable, 1);
        chk("t1_re", read_enable, 0);
        chk("t1_addr", address, 24'h10);
        chk("t1_busy", busy, 1);
        chk("t1_nodone", done, 0);
        cyc(1);
        chk("t1_done0", done, 4'b0001);
        chk("t1_we_off", write_enable, 0);
        req_valid[0] = 1'b0;
        set_req(1, 1, 0, 24'h10, '0);
        cyc(1);
        chk("t1_idle_busy", busy, 0);
        cyc(1);
        chk("t1_re", read_enable, 1);
        chk("t1_raddr", address, 24'h10);
        cyc(1);
        chk("t1_done1", done, 4'b0010);
        chk("t1_rdata", rdata == PAT, 1);
        req_valid = '0;

        // two simultaneous reads
        do_reset();
        set_req(0, 1, 0, 24'h3, '0);
        set_req(2, 1, 0, 24'h4, '0);
        cyc(2);
        chk("t2_done0", done, 4'b0001);
        chk("t2_rdata0", rdata[63:0], mem_init(3)[63:0]);
        req_valid[0] = 1'b0;
        cyc(1);
        chk("t2_gap", done, 0);
        cyc(2);
        chk("t2_done2", done, 4'b0100);
        chk("t2_rdata2", rdata == mem_init(4), 1);
        req_valid = '0;

        // all four held: round-robin order with a 3-cycle period
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_req(i, 1, 0, ADDR_W'(i + 1), '0);
        cyc(2);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc(3);
            chk("t3_rr_done", done, 64'(1 << (k % 4)));
            chk("t3_rr_rdata", rdata == mem_init(k % 4 + 1), 1);
        end
        req_valid = '0;

        // valid dropped and inputs changed mid-access; writes leave rdata alone
        set_req(1, 1, 1, 24'h5, W5);
        cyc(2);
        chk("t3b_we", write_enable, 1);
        chk("t3b_addr", address, 24'h5);
        set_req(1, 0, 1, 24'h9, '0);
        cyc(1);
        chk("t3b_done", done, 4'b0010);
        chk("t3b_addr_hold", address, 24'h5);
        chk("t3b_wdata_hold", write_data == W5, 1);
        chk("t3b_rdata_kept", rdata == mem_init(2), 1);

        // ACCESS_CYCLES=3 instance: three strobe cycles, done on the fourth
        do_reset();
        set_req(3, 1, 0, 24'h8, '0);
        cyc(1);
        chk("t4_re_c1", re3, 1);
        chk("t4_busy", busy3, 1);
        chk("t4_addr", addr3, 24'h8);
        cyc(1);
        chk("t4_re_c2", re3, 1);
        cyc(1);
        chk("t4_re_c3", re3, 1);
        chk("t4_nodone", done3, 0);
        cyc(1);
        chk("t4_re_off", re3, 0);
        chk("t4_done3", done3, 4'b1000);
        chk("t4_rdata", rdata3 == rd3, 1);
        chk("t4_wdata", wd3 == '0, 1);
        req_valid = '0;

        // reset during a write access
        do_reset();
        set_req(2, 1, 1, 24'h6, W5);
        cyc(1);
        chk("t5_we", write_enable, 1);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_we", write_enable, 0);
        chk("t5_async_busy", busy, 0);
        cyc(1);
        chk("t5_nodone", done, 0);
        rst = 1'b0;
        set_req(0, 1, 0, 24'h7, '0);
        cyc(2);
        chk("t5_first_0", done, 4'b0001);
        chk("t5_rdata", rdata == mem_init(7), 1);
        req_valid = '0;

        // requesters 0 and 3 held high
        do_reset();
        set_req(0, 1, 0, 24'h1, '0);
        set_req(3, 1, 0, 24'h2, '0);
        cyc(2);
        chk("t6_g1", done, 4'b0001);
        cyc(3);
`ifdef SRAM_ARB_FIXED_PRIO_EN
        chk("t6_g2", done, 4'b0001);
`else
        chk("t6_g2", done, 4'b1000);
`endif
        cyc(3);
        chk("t6_g3", done, 4'b0001);
        req_valid[0] = 1'b0;
        cyc(3);
        chk("t6_g4", done, 4'b1000);
        req_valid = '0;

        cyc(2);
        chk("strobe_excl", both_hi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
